// File: rtl/axi_write_responder_if.sv
// AXI-style write channel bundle (AW, W, B) plus the debug read port of the
// write responder. The slave modport is the responder's view.
interface axi_write_responder_if;
  logic       AWVALID;
  logic       AWREADY;
  logic [7:0] AWADDR;
  logic [3:0] AWID;
  logic [3:0] AWLEN;
  logic       WVALID;
  logic       WREADY;
  logic [7:0] WDATA;
  logic       WLAST;
  logic       BVALID;
  logic       BREADY;
  logic [3:0] BID;
  logic [1:0] BRESP;
  logic [7:0] DBG_ADDR;
  logic [7:0] DBG_DATA;

  modport slave (
    input  AWVALID, AWADDR, AWID, AWLEN,
    input  WVALID, WDATA, WLAST,
    input  BREADY,
    input  DBG_ADDR,
    output AWREADY, WREADY, BVALID, BID, BRESP,
    output DBG_DATA
  );

  modport master (
    output AWVALID, AWADDR, AWID, AWLEN,
    output WVALID, WDATA, WLAST,
    output BREADY,
    output DBG_ADDR,
    input  AWREADY, WREADY, BVALID, BID, BRESP,
    input  DBG_DATA
  );
endinterface

// File: rtl/axi_write_responder.sv
// Single-outstanding write responder backed by a 256x8 byte array. Addresses
// 8'hF0-8'hFF are protected; bursts that break length or address rules get SLVERR.
module axi_write_responder (
  input  logic                   clk,
  input  logic                   rst,
  axi_write_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RESP
  } state_t;

  localparam logic [7:0] PROT_BASE = 8'hF0;
  localparam logic [4:0] BEAT_SAT  = 5'd16;

  state_t     state;
  logic [7:0] mem [256];
  logic [7:0] addr;
  logic [3:0] id;
  logic [3:0] len;
  logic [4:0] beat_cnt;
  logic       err;

  logic beat;
  logic dst_bad;
  logic over;
  logic early_last;
  logic beat_err;
  logic do_write;

  // NOTE: every signal gets a value at the top of always_comb so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    beat       = 1'b0;
    dst_bad    = 1'b0;
    over       = 1'b0;
    early_last = 1'b0;
    beat_err   = 1'b0;
    do_write   = 1'b0;
    if (state == ST_WDATA) begin
      beat       = bus.WVALID && bus.WREADY;
      dst_bad    = addr >= PROT_BASE;
      over       = beat_cnt > {1'b0, len};
      early_last = bus.WLAST && (beat_cnt != {1'b0, len});
      beat_err   = beat && (dst_bad || over || early_last);
      do_write   = beat && !dst_bad && !over;
    end
  end

  // NOTE: the array must clear on reset, so it is built from resettable flops
  // rather than a RAM macro, which cannot be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[addr] <= bus.WDATA;
    end
  end

  assign bus.DBG_DATA = mem[bus.DBG_ADDR];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus.AWREADY <= 1'b1;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BID     <= '0;
      bus.BRESP   <= '0;
      addr        <= '0;
      id          <= '0;
      len         <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.AWVALID) begin
            addr        <= bus.AWADDR;
            id          <= bus.AWID;
            len         <= bus.AWLEN;
            beat_cnt    <= '0;
            err         <= 1'b0;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b1;
            state       <= ST_WDATA;
          end
        end

        ST_WDATA: begin
          if (beat) begin
            // Wrap past 8'hFF is legal; only the protected window flags an error.
            addr <= addr + 8'd1;
            if (beat_cnt != BEAT_SAT) beat_cnt <= beat_cnt + 5'd1;
            err <= err || beat_err;
            if (bus.WLAST) begin
              bus.WREADY <= 1'b0;
              bus.BVALID <= 1'b1;
              bus.BID    <= id;
              bus.BRESP  <= (err || beat_err) ? 2'b10 : 2'b00;
              state      <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (bus.BREADY) begin
            bus.BVALID  <= 1'b0;
            bus.AWREADY <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_responder.sv
// Randomised and directed bench for axi_write_responder, checked against a
// byte-array reference model that applies the burst rules beat by beat.
module tb_axi_write_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_write_responder_if bus ();

  axi_write_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model_mem [256];
  logic [7:0] bdata [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem();
    for (int i = 0; i < 256; i++) begin
      bus.DBG_ADDR = 8'(i);
      #1;
      check($sformatf("mem[%02h]", i), {24'h0, bus.DBG_DATA}, {24'h0, model_mem[i]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, {31'h0, bus.AWREADY}, 32'd1);
    check({tag, "_wready"},  {31'h0, bus.WREADY},  32'd0);
    check({tag, "_bvalid"},  {31'h0, bus.BVALID},  32'd0);
    check({tag, "_bid"},     {28'h0, bus.BID},     32'd0);
    check({tag, "_bresp"},   {30'h0, bus.BRESP},   32'd0);
  endtask

  // One full transaction: optional W noise while idle, address, beats with
  // random gaps, then a response held off for bdelay cycles.
  task automatic run_burst(input logic [7:0] a, input logic [3:0] id, input logic [3:0] len,
                           input int nbeats, input int gap_max, input int bdelay);
    logic [7:0] cur;
    bit         err;
    logic [1:0] exp_resp;
    int         c;
    bit         last;

    // Data offered while idle must be ignored.
    bus.WVALID = 1'b1;
    bus.WDATA  = 8'hCC;
    bus.WLAST  = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    check("idle_wready", {31'h0, bus.WREADY},  32'd0);
    check("idle_bvalid", {31'h0, bus.BVALID},  32'd0);

    check("aw_ready", {31'h0, bus.AWREADY}, 32'd1);
    bus.AWVALID = 1'b1;
    bus.AWADDR  = a;
    bus.AWID    = id;
    bus.AWLEN   = len;
    tick();
    bus.AWVALID = 1'b0;
    check("wready_after_aw",  {31'h0, bus.WREADY},  32'd1);
    check("awready_after_aw", {31'h0, bus.AWREADY}, 32'd0);

    cur = a;
    err = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        tick();
        check("gap_wready", {31'h0, bus.WREADY}, 32'd1);
      end
      last        = (i == nbeats - 1);
      bus.WVALID  = 1'b1;
      bus.WDATA   = bdata[i];
      bus.WLAST   = last;
      tick();
      bus.WVALID  = 1'b0;
      bus.WLAST   = 1'b0;

      c = (i > 16) ? 16 : i;
      if (c <= int'(len) && cur < 8'hF0) model_mem[cur] = bdata[i];
      if (cur >= 8'hF0 || c > int'(len) || (last && c != int'(len))) err = 1'b1;
      cur = cur + 8'd1;

      if (last) begin
        check("last_wready", {31'h0, bus.WREADY}, 32'd0);
        check("last_bvalid", {31'h0, bus.BVALID}, 32'd1);
      end else begin
        check("beat_wready", {31'h0, bus.WREADY}, 32'd1);
        check("beat_bvalid", {31'h0, bus.BVALID}, 32'd0);
      end
    end

    exp_resp = err ? 2'b10 : 2'b00;
    for (int d = 0; d <= bdelay; d++) begin
      bus.BREADY  = (d == bdelay);
      // An address offered during the response must not be taken.
      bus.AWVALID = 1'($urandom_range(0, 1));
      bus.AWADDR  = 8'($urandom);
      check("resp_bvalid",  {31'h0, bus.BVALID},  32'd1);
      check("resp_bid",     {28'h0, bus.BID},     {28'h0, id});
      check("resp_bresp",   {30'h0, bus.BRESP},   {30'h0, exp_resp});
      check("resp_awready", {31'h0, bus.AWREADY}, 32'd0);
      check("resp_wready",  {31'h0, bus.WREADY},  32'd0);
      tick();
    end
    bus.BREADY  = 1'b0;
    bus.AWVALID = 1'b0;
    check("post_bvalid",  {31'h0, bus.BVALID},  32'd0);
    check("post_awready", {31'h0, bus.AWREADY}, 32'd1);
    check("post_wready",  {31'h0, bus.WREADY},  32'd0);
    check("post_bid",     {28'h0, bus.BID},     {28'h0, id});
    check("post_bresp",   {30'h0, bus.BRESP},   {30'h0, exp_resp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rlen;
    int         nb;

    bus.AWVALID  = 1'b0;
    bus.AWADDR   = '0;
    bus.AWID     = '0;
    bus.AWLEN    = '0;
    bus.WVALID   = 1'b0;
    bus.WDATA    = '0;
    bus.WLAST    = 1'b0;
    bus.BREADY   = 1'b0;
    bus.DBG_ADDR = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    #22;
    check_reset_outputs("por");
    check_mem();
    rst = 1'b0;
    tick();

    // Single beat.
    bdata[0] = 8'h5A;
    run_burst(8'h01, 4'd1, 4'd0, 1, 0, 0);
    check_mem();

    // Burst running into the protected window.
    bdata[0] = 8'h01; bdata[1] = 8'h02; bdata[2] = 8'h03;
    run_burst(8'hEE, 4'd2, 4'd2, 3, 0, 0);
    check_mem();

    // Early WLAST.
    bdata[0] = 8'hA1; bdata[1] = 8'hA2;
    run_burst(8'h10, 4'd3, 4'd3, 2, 0, 0);
    check_mem();

    // Response backpressure.
    bdata[0] = 8'h77;
    run_burst(8'h30, 4'd9, 4'd0, 1, 0, 5);

    // Overlong burst.
    bdata[0] = 8'h11; bdata[1] = 8'h22; bdata[2] = 8'h33;
    run_burst(8'h40, 4'd4, 4'd0, 3, 1, 0);
    check_mem();

    // Wrap 8'hFF -> 8'h00 with the protected beats discarded.
    bdata[0] = 8'hB0; bdata[1] = 8'hB1; bdata[2] = 8'hB2; bdata[3] = 8'hB3;
    run_burst(8'hFE, 4'd5, 4'd3, 4, 0, 1);
    check_mem();

    // Reset mid-burst.
    bus.AWVALID = 1'b1; bus.AWADDR = 8'h20; bus.AWID = 4'd7; bus.AWLEN = 4'd3;
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b1; bus.WDATA = 8'hEE; bus.WLAST = 1'b0;
    tick();
    bus.WVALID  = 1'b0;
    bus.DBG_ADDR = 8'h20;
    #1;
    check("pre_rst_mem20", {24'h0, bus.DBG_DATA}, 32'h0000_00EE);
    rst = 1'b1;
    #2;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    check_mem();
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_reset_outputs("after_rst");
    end

    // Randomised bursts.
    for (int t = 0; t < 60; t++) begin
      rlen = 4'($urandom_range(0, 15));
      nb   = ($urandom_range(0, 9) < 7) ? int'(rlen) + 1 : $urandom_range(1, int'(rlen) + 4);
      for (int i = 0; i < nb; i++) bdata[i] = 8'($urandom);
      run_burst(($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hE0, 8'hFF)) : 8'($urandom),
                4'($urandom), rlen, nb, 2, $urandom_range(0, 3));
      if (t % 15 == 14) check_mem();
    end
    check_mem();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
